// File: rtl/rv32i_mem_sequencer_pkg.sv
// Shared definitions for the memory sequencer: FSM states, access op and
// size encodings, and the alignment helper used when accepting requests.
package rv32i_mem_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MEM  = 2'd1,
        RESP = 2'd2
    } mem_seq_state_t;

    // Access operation encodings (2'b10 is illegal)
    localparam logic [1:0] LOAD      = 2'b00;
    localparam logic [1:0] STORE     = 2'b01;
    localparam logic [1:0] MEM_NOOP  = 2'b11;

    // Access size encodings (2'b11 is illegal)
    localparam logic [1:0] BYTE      = 2'b00;
    localparam logic [1:0] HALF_WORD = 2'b01;
    localparam logic [1:0] WORD      = 2'b10;

    // True when the byte address is not naturally aligned for the access size
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic result;
        result = 1'b0;
        case (size)
            HALF_WORD: result = addr_lo[0];
            WORD:      result = (addr_lo != 2'b00);
            default:   result = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/rv32i_lsu_lane_format.sv
// Combinational lane formatter: builds byte enables and lane-replicated
// store data, and extracts/extends load data from a read word.
module rv32i_lsu_lane_format
    import rv32i_mem_sequencer_pkg::*;
(
    input  logic        is_store,
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_lanes,
    output logic [31:0] load_data
);

    logic [7:0]  rd_lane [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        fill;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign rd_lane[gi] = rdata[8*gi +: 8];
        end
    endgenerate

    assign byte_sel = rd_lane[addr_lo];
    assign half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    // Store lane replication and byte enables; loads always read the full word
    always_comb begin
        be          = 4'b1111;
        wdata_lanes = 32'h0;
        if (is_store) begin
            case (size)
                BYTE: begin
                    wdata_lanes = {4{wdata[7:0]}};
                    be          = 4'b0001 << addr_lo;
                end
                HALF_WORD: begin
                    wdata_lanes = {2{wdata[15:0]}};
                    be          = addr_lo[1] ? 4'b1100 : 4'b0011;
                end
                default: begin
                    wdata_lanes = wdata;
                    be          = 4'b1111;
                end
            endcase
        end
    end

    // Load lane selection followed by sign or zero extension
    always_comb begin
        fill      = 1'b0;
        load_data = rdata;
        case (size)
            BYTE: begin
                fill      = ~is_unsigned & byte_sel[7];
                load_data = {{24{fill}}, byte_sel};
            end
            HALF_WORD: begin
                fill      = ~is_unsigned & half_sel[15];
                load_data = {{16{fill}}, half_sel};
            end
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/rv32i_mem_sequencer.sv
// Memory port sequencer: arbitrates fetch vs. load/store (data first),
// rejects misaligned/illegal accesses, runs one bus transaction at a time
// with a timeout, and returns a one-cycle done pulse to the owner.
module rv32i_mem_sequencer
    import rv32i_mem_sequencer_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_req,
    input  logic [31:0] fetch_addr,
    output logic        fetch_done,
    output logic [31:0] fetch_rdata,
    output logic        fetch_err,
    input  logic        data_req,
    input  logic [1:0]  data_op,
    input  logic [1:0]  data_size,
    input  logic        data_unsigned,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_done,
    output logic [31:0] data_rdata,
    output logic        data_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    mem_seq_state_t   state_reg;
    logic             owner_data_reg;
    logic             store_reg;
    logic [1:0]       size_reg;
    logic [1:0]       addr_lo_reg;
    logic             unsigned_reg;
    logic [CNT_W-1:0] timeout_cnt_reg;

    logic             in_idle;
    logic             fmt_store;
    logic [1:0]       fmt_size;
    logic [1:0]       fmt_addr_lo;
    logic             fmt_unsigned;
    logic [3:0]       fmt_be;
    logic [31:0]      fmt_wdata;
    logic [31:0]      fmt_load;
    logic             data_illegal;
    logic             data_bad_align;

    // The formatter sees live request inputs while accepting, latched ones in MEM
    assign in_idle      = (state_reg == IDLE);
    assign fmt_store    = in_idle ? (data_op == STORE) : store_reg;
    assign fmt_size     = in_idle ? data_size : size_reg;
    assign fmt_addr_lo  = in_idle ? data_addr[1:0] : addr_lo_reg;
    assign fmt_unsigned = in_idle ? data_unsigned : unsigned_reg;

    assign data_illegal   = (data_op == 2'b10) || (data_size == 2'b11);
    assign data_bad_align = is_misaligned(data_size, data_addr[1:0]);

    rv32i_lsu_lane_format u_lane_format (
        .is_store    (fmt_store),
        .size        (fmt_size),
        .addr_lo     (fmt_addr_lo),
        .is_unsigned (fmt_unsigned),
        .wdata       (data_wdata),
        .rdata       (mem_rdata),
        .be          (fmt_be),
        .wdata_lanes (fmt_wdata),
        .load_data   (fmt_load)
    );

    // Sequencer FSM with arbitration, request latches, timeout and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            owner_data_reg  <= 1'b0;
            store_reg       <= 1'b0;
            size_reg        <= 2'b00;
            addr_lo_reg     <= 2'b00;
            unsigned_reg    <= 1'b0;
            timeout_cnt_reg <= '0;
            fetch_done      <= 1'b0;
            fetch_rdata     <= 32'h0;
            fetch_err       <= 1'b0;
            data_done       <= 1'b0;
            data_rdata      <= 32'h0;
            data_err        <= 1'b0;
            mem_req         <= 1'b0;
            mem_we          <= 1'b0;
            mem_addr        <= 32'h0;
            mem_be          <= 4'h0;
            mem_wdata       <= 32'h0;
            busy            <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (data_req) begin
                        owner_data_reg <= 1'b1;
                        busy           <= 1'b1;
                        if (data_op == MEM_NOOP) begin
                            state_reg  <= RESP;
                            data_done  <= 1'b1;
                            data_err   <= 1'b0;
                            data_rdata <= 32'h0;
                        end else if (data_illegal || data_bad_align) begin
                            state_reg  <= RESP;
                            data_done  <= 1'b1;
                            data_err   <= 1'b1;
                            data_rdata <= 32'h0;
                        end else begin
                            state_reg       <= MEM;
                            store_reg       <= (data_op == STORE);
                            size_reg        <= data_size;
                            addr_lo_reg     <= data_addr[1:0];
                            unsigned_reg    <= data_unsigned;
                            timeout_cnt_reg <= '0;
                            mem_req         <= 1'b1;
                            mem_we          <= (data_op == STORE);
                            mem_addr        <= {data_addr[31:2], 2'b00};
                            mem_be          <= fmt_be;
                            mem_wdata       <= fmt_wdata;
                        end
                    end else if (fetch_req) begin
                        owner_data_reg <= 1'b0;
                        busy           <= 1'b1;
                        if (fetch_addr[1:0] != 2'b00) begin
                            state_reg   <= RESP;
                            fetch_done  <= 1'b1;
                            fetch_err   <= 1'b1;
                            fetch_rdata <= 32'h0;
                        end else begin
                            state_reg       <= MEM;
                            store_reg       <= 1'b0;
                            size_reg        <= WORD;
                            addr_lo_reg     <= 2'b00;
                            unsigned_reg    <= 1'b0;
                            timeout_cnt_reg <= '0;
                            mem_req         <= 1'b1;
                            mem_we          <= 1'b0;
                            mem_addr        <= {fetch_addr[31:2], 2'b00};
                            mem_be          <= 4'b1111;
                            mem_wdata       <= 32'h0;
                        end
                    end
                end
                MEM: begin
                    if (mem_ack) begin
                        // Ack wins even on the cycle the timeout would expire
                        state_reg <= RESP;
                        mem_req   <= 1'b0;
                        if (owner_data_reg) begin
                            data_done  <= 1'b1;
                            data_err   <= 1'b0;
                            data_rdata <= store_reg ? 32'h0 : fmt_load;
                        end else begin
                            fetch_done  <= 1'b1;
                            fetch_err   <= 1'b0;
                            fetch_rdata <= mem_rdata;
                        end
                    end else if (timeout_cnt_reg == CNT_LAST) begin
                        state_reg <= RESP;
                        mem_req   <= 1'b0;
                        if (owner_data_reg) begin
                            data_done  <= 1'b1;
                            data_err   <= 1'b1;
                            data_rdata <= 32'h0;
                        end else begin
                            fetch_done  <= 1'b1;
                            fetch_err   <= 1'b1;
                            fetch_rdata <= 32'h0;
                        end
                    end else if (timeout_cnt_reg != CNT_MAX) begin
                        timeout_cnt_reg <= timeout_cnt_reg + 1'b1;
                    end
                end
                RESP: begin
                    state_reg   <= IDLE;
                    busy        <= 1'b0;
                    fetch_done  <= 1'b0;
                    fetch_rdata <= 32'h0;
                    fetch_err   <= 1'b0;
                    data_done   <= 1'b0;
                    data_rdata  <= 32'h0;
                    data_err    <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    busy      <= 1'b0;
                    mem_req   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/rv32i_mem_sequencer.md
# rv32i_mem_sequencer

Sequences the core's single memory port. It arbitrates between the instruction-fetch requester and the load/store requester, formats byte, half-word and word accesses into word-aligned bus transactions with byte enables, and aligns and extends load data. It also rejects misaligned accesses and bounds each memory transaction with a timeout. It sits between the multicycle control FSM (fetch and memory stages) and the external memory bus.

## Interface
Parameters:
- TIMEOUT_CYCLES, default 255: maximum number of cycles `mem_req` stays high without `mem_ack` before the transaction is aborted with an error. Legal range is 1 or more.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- fetch_req  in  1  instruction-fetch request; level signal, held with `fetch_addr` stable until `fetch_done`.
- fetch_addr  in  32  fetch byte address.
- fetch_done  out  1  one-cycle completion pulse for the fetch requester.
- fetch_rdata  out  32  fetched instruction; valid with `fetch_done`, 0 otherwise.
- fetch_err  out  1  error flag; valid with `fetch_done`.
- data_req  in  1  load/store request; level signal, held with all `data_*` inputs stable until `data_done`.
- data_op  in  2  LOAD=00, STORE=01, MEM_NOOP=11; 10 is illegal.
- data_size  in  2  BYTE=00, HALF_WORD=01, WORD=10; 11 is illegal.
- data_unsigned  in  1  when 1, loads are zero-extended; when 0, sign-extended.
- data_addr  in  32  data byte address.
- data_wdata  in  32  store data, right-justified.
- data_done  out  1  one-cycle completion pulse for the data requester.
- data_rdata  out  32  extended load data; 0 for stores, NOOP and errors.
- data_err  out  1  error flag; valid with `data_done`.
- mem_req  out  1  bus request, registered; held until `mem_ack`.
- mem_we  out  1  1 for store transactions.
- mem_addr  out  32  word address; bits [1:0] are always 0.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-replicated store data.
- mem_ack  in  1  one-cycle acknowledge; `mem_rdata` is valid in the same cycle.
- mem_rdata  in  32  read data.
- busy  out  1  high whenever the state is not IDLE.

## Operation
States and transitions:
- IDLE: evaluates requests.
  - With `data_req` high: MEM_NOOP goes to RESP with err=0. Misaligned or illegal op/size goes to RESP with err=1. Otherwise latch the request and go to MEM.
  - With only `fetch_req` high: `fetch_addr`[1:0]≠0 goes to RESP with err=1. Otherwise go to MEM as a word read.
- MEM: `mem_req` is high.
  - `mem_ack` goes to RESP with the formatted rdata.
  - Timeout expiry goes to RESP with err=1.
- RESP: the owner's `done` is high for exactly 1 cycle, then the state returns to IDLE.

Arbitration:
- Fixed priority: data wins over fetch. A losing fetch stays pending, receives no `done`, and is served on a later IDLE.

Alignment rules:
- HALF_WORD requires addr[0]=0.
- WORD requires addr[1:0]=0.
- A rejected access never asserts `mem_req`.

Store formatting:
- BYTE: `mem_wdata`={4{wdata[7:0]}}, `mem_be`=4'b0001<<addr[1:0].
- HALF_WORD: `mem_wdata`={2{wdata[15:0]}}, `mem_be`= addr[1] ? 1100 : 0011.
- WORD: `mem_wdata`=wdata, `mem_be`=1111.

Load formatting:
- Reads use `mem_be`=1111.
- Select the lane by the latched addr[1:0], then sign- or zero-extend to 32 bits according to `data_unsigned`.

Error and boundary rules:
- Timeout counter: cleared on entering MEM, increments each MEM cycle without ack. It is $clog2(TIMEOUT_CYCLES+1) bits and saturates. When it equals TIMEOUT_CYCLES-1 with no ack, the next state is RESP with err=1 and `mem_req` drops.
- Ack in the same cycle as timeout expiry: the ack wins, err=0.
- `mem_ack` in IDLE or RESP is ignored.
- `mem_rdata` is sampled only in MEM.
- Reset mid-operation: the state goes to IDLE immediately and `mem_req` drops asynchronously. The abandoned bus transaction is the memory's responsibility.

## Timing
- Reset values: state=IDLE; every output is 0, including `mem_addr`, `mem_be` and `busy`.
- Accepted access, request seen in IDLE in cycle 0:
  - `mem_req` high from cycle 1.
  - Ack in cycle k≥1 gives `done` in cycle k+1 and IDLE in cycle k+2.
  - Zero-wait memory gives a request-to-done latency of 2 cycles.
- Rejected access or NOOP: `done` in cycle 1 and no bus activity.
- All outputs are registered.
- Requesters sample `done` in the cycle it is high and deassert `req` by the next edge. IDLE therefore never re-accepts a completed request.
- Bus signals `mem_we`, `mem_addr`, `mem_be` and `mem_wdata` are stable for the whole time `mem_req` is high.

## Structure
Shared package additions:
- Typedef `mem_seq_state_t` {IDLE, MEM, RESP}.
- The op encodings LOAD/STORE/MEM_NOOP and size encodings BYTE/HALF_WORD/WORD, reused from the package.

Sub-module:
- `rv32i_lsu_lane_format`: combinational; produces `mem_be` and `mem_wdata`, and extracts and extends load data. It is shared with any future cache path.

Sequencer body:
- FSM, arbiter, request latches and timeout counter.

## Test plan
- SB addr=0x1003, wdata=0xA5 -> `mem_addr`=0x1000, `mem_be`=1000, `mem_wdata`=0xA5A5A5A5, `mem_we`=1; `data_done` 1 cycle after ack, err=0.
- LH addr=0x2002 (signed), mem_rdata=0x8001_1234 -> `data_rdata`=0xFFFF8001. LHU same address -> `data_rdata`=0x00008001.
- LW addr=0x3002 -> `data_done` in cycle 1, err=1, `mem_req` never asserted. `fetch_addr`=0x4001 -> `fetch_err`=1.
- `fetch_req` and `data_req` both high in cycle 0 -> data transaction first. Fetch served after, with `fetch_done` only after `data_done`.
- TIMEOUT_CYCLES=4, no ack -> `mem_req` high exactly 4 cycles, then `data_done` with err=1. Ack on cycle 4 instead -> err=0.
- `rst` asserted while in MEM -> `mem_req`, `busy` and all done outputs go to 0 immediately. After release, a new LW at 0x0 completes normally.
